knn_vote: RTL and testbench

Majority-vote classifier directly downstream of the KNN neighbour-search stage. Takes the K-entry nearest-neighbour list (sorted nearest first, with per-entry valid bits) and snapshots it on `start`. It counts label occurrences sequentially and returns the winning class with its vote count. The result is exposed to the software register file as the final classification for the current test point.

---
 rtl/knn_vote_pkg.sv | 22 ++
 rtl/knn_vote_cnt.sv | 33 +++
 rtl/knn_vote.sv | 123 ++++++++++++
 tb/tb_knn_vote.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/knn_vote_pkg.sv
// Shared KNN definitions: default neighbour count / label width and the
// vote FSM encoding used by knn_vote.
package knn_vote_pkg;

   localparam int K_DEF       = 10;
   localparam int LABEL_W_DEF = 4;

   // Counter width able to hold a count of 0..k.
   function automatic int cnt_w(input int k);
      return $clog2(k + 1);
   endfunction

   localparam int CNT_W_DEF = cnt_w(K_DEF);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_COUNT  = 2'd1,
      ST_SELECT = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/knn_vote_cnt.sv
// Bank of per-class vote counters: sync clear-all, single increment port,
// combinational read port.
module knn_vote_cnt
   import knn_vote_pkg::*;
#(
   parameter int LABEL_W = LABEL_W_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               inc_en,
   input  logic [LABEL_W-1:0] inc_addr,
   input  logic [LABEL_W-1:0] rd_addr,
   output logic [CNT_W-1:0]   rd_data
);

   localparam int NUM_CLS = 2 ** LABEL_W;

   logic [NUM_CLS-1:0][CNT_W-1:0] cnt;

   for (genvar c = 0; c < NUM_CLS; c++) begin : g_cnt
      always_ff @(posedge clk) begin
         if (!rst || clr)
            cnt[c] <= '0;
         else if (inc_en && (inc_addr == LABEL_W'(c)))
            cnt[c] <= cnt[c] + CNT_W'(1);
      end
   end

   assign rd_data = cnt[rd_addr];

endmodule

// File: rtl/knn_vote.sv
// Majority vote over the K nearest neighbours: snapshot, count per label,
// then pick the highest count with ties going to the nearest neighbour.
module knn_vote
   import knn_vote_pkg::*;
#(
   parameter int K       = K_DEF,
   parameter int LABEL_W = LABEL_W_DEF,
   parameter int CNT_W   = cnt_w(K)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [K*LABEL_W-1:0] nb_label,
   input  logic [K-1:0]         nb_valid,
   output logic                 busy,
   output logic                 out_valid,
   output logic [LABEL_W-1:0]   out_class,
   output logic [CNT_W-1:0]     out_votes,
   output logic                 out_empty
);

   localparam int IDX_W = (K > 1) ? $clog2(K) : 1;

   state_t                       state;
   logic [IDX_W-1:0]             idx;
   logic [K-1:0][LABEL_W-1:0]    lbl_q;
   logic [K-1:0]                 vld_q;
   logic [LABEL_W-1:0]           best_class;
   logic [CNT_W-1:0]             best_votes;

   logic [LABEL_W-1:0]           cur_lbl;
   logic                         cur_vld;
   logic [CNT_W-1:0]             rd_cnt;
   logic                         last;
   logic                         sel_upd;
   logic                         cnt_clr;
   logic                         cnt_inc;

   assign cur_lbl = lbl_q[idx];
   assign cur_vld = vld_q[idx];
   assign last    = (idx == IDX_W'(K - 1));
   // Strict compare: an equal count later in the list never displaces the
   // earlier (nearer) label.
   assign sel_upd = cur_vld && (rd_cnt > best_votes);
   assign cnt_clr = (state == ST_IDLE) && start;
   assign cnt_inc = (state == ST_COUNT) && cur_vld;

   knn_vote_cnt #(
      .LABEL_W (LABEL_W),
      .CNT_W   (CNT_W)
   ) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .clr      (cnt_clr),
      .inc_en   (cnt_inc),
      .inc_addr (cur_lbl),
      .rd_addr  (cur_lbl),
      .rd_data  (rd_cnt)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= ST_IDLE;
         idx        <= '0;
         lbl_q      <= '0;
         vld_q      <= '0;
         best_class <= '0;
         best_votes <= '0;
         busy       <= 1'b0;
         out_valid  <= 1'b0;
         out_class  <= '0;
         out_votes  <= '0;
         out_empty  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  lbl_q      <= nb_label;
                  vld_q      <= nb_valid;
                  idx        <= '0;
                  best_class <= '0;
                  best_votes <= '0;
                  busy       <= 1'b1;
                  state      <= ST_COUNT;
               end
            end
            ST_COUNT: begin
               if (last) begin
                  idx   <= '0;
                  state <= ST_SELECT;
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end
            ST_SELECT: begin
               if (sel_upd) begin
                  best_class <= cur_lbl;
                  best_votes <= rd_cnt;
               end
               if (last) begin
                  // Outputs take the final comparison directly so the result
                  // is visible in the DONE cycle itself.
                  idx       <= '0;
                  out_valid <= 1'b1;
                  out_class <= sel_upd ? cur_lbl : best_class;
                  out_votes <= sel_upd ? rd_cnt : best_votes;
                  out_empty <= (vld_q == '0);
                  state     <= ST_DONE;
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end
            ST_DONE: begin
               out_valid <= 1'b0;
               busy      <= 1'b0;
               state     <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_knn_vote.sv
// Scoreboard bench for knn_vote: stimulus pushes expected results, a
// negedge monitor pops and compares on every out_valid.
module tb_knn_vote;

   localparam int K       = 10;
   localparam int LABEL_W = 4;
   localparam int CNT_W   = 4;
   localparam int LAT     = 2 * K + 1;

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic                 start = 1'b0;
   logic [K*LABEL_W-1:0] nb_label = '0;
   logic [K-1:0]         nb_valid = '0;
   logic                 busy;
   logic                 out_valid;
   logic [LABEL_W-1:0]   out_class;
   logic [CNT_W-1:0]     out_votes;
   logic                 out_empty;

   typedef struct {
      int cls;
      int votes;
      int empty;
      int acc;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   bcnt     = 0;

   knn_vote #(.K(K), .LABEL_W(LABEL_W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .nb_label  (nb_label),
      .nb_valid  (nb_valid),
      .busy      (busy),
      .out_valid (out_valid),
      .out_class (out_class),
      .out_votes (out_votes),
      .out_empty (out_empty)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [K*LABEL_W-1:0] mk(input int a0, input int a1, input int a2,
      input int a3, input int a4, input int a5, input int a6, input int a7, input int a8,
      input int a9);
      int a[K];
      logic [K*LABEL_W-1:0] r;
      a = '{a0, a1, a2, a3, a4, a5, a6, a7, a8, a9};
      r = '0;
      for (int i = 0; i < K; i++) r[i*LABEL_W +: LABEL_W] = LABEL_W'(a[i]);
      return r;
   endfunction

   // Monitor: busy run length is counted including the out_valid cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (busy) bcnt++; else bcnt = 0;
         if (out_valid) begin
            if (sb.size() == 0) begin
               chk("spurious_out_valid", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("latency",   cyc - e.acc, LAT);
               chk("busy_len",  bcnt, LAT);
               chk("out_class", int'(out_class), e.cls);
               chk("out_votes", int'(out_votes), e.votes);
               chk("out_empty", int'(out_empty), e.empty);
            end
         end
      end
   end

   task automatic check_idle_outputs(input string name, input int c, input int v, input int e);
      chk({name, "_valid"}, int'(out_valid), 0);
      chk({name, "_busy"},  int'(busy), 0);
      chk({name, "_class"}, int'(out_class), c);
      chk({name, "_votes"}, int'(out_votes), v);
      chk({name, "_empty"}, int'(out_empty), e);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (busy) chk("wait_idle_timeout", 1, 0);
   endtask

   // Issue one vote, then scramble the inputs to prove the snapshot holds.
   task automatic vote(input logic [K*LABEL_W-1:0] lb, input logic [K-1:0] vl,
      input int c, input int v, input int e);
      exp_t x;
      @(negedge clk);
      nb_label = lb;
      nb_valid = vl;
      start    = 1'b1;
      x.cls = c; x.votes = v; x.empty = e; x.acc = cyc;
      sb.push_back(x);
      @(posedge clk);
      #1;
      start    = 1'b0;
      nb_label = (K*LABEL_W)'({$urandom, $urandom});
      nb_valid = K'($urandom);
      wait_idle();
      repeat (2) @(negedge clk);
      check_idle_outputs("held", c, v, e);
   endtask

   initial begin
      exp_t x;
      repeat (3) @(negedge clk);
      check_idle_outputs("reset", 0, 0, 0);
      rst = 1'b1;

      vote(mk(3,3,3,3,3,3,3,3,3,3), 10'h3FF, 3, 10, 0);
      vote(mk(5,2,2,5,7,7,7,5,2,1), 10'h3FF, 5, 3, 0);
      vote(mk(1,1,2,7,7,7,7,7,7,7), 10'h007, 1, 2, 0);
      vote(mk(4,9,9,9,4,6,6,6,6,1), 10'h3FF, 6, 4, 0);
      vote(mk(0,0,0,0,0,0,0,0,0,15), 10'h200, 15, 1, 0);
      vote(mk(8,8,8,8,8,8,8,8,8,8), 10'h000, 0, 0, 1);

      // Second start during COUNT with other labels must be ignored.
      @(negedge clk);
      nb_label = mk(2,2,6,6,6,2,9,9,9,9);
      nb_valid = 10'h3FF;
      start = 1'b1;
      x.cls = 9; x.votes = 4; x.empty = 0; x.acc = cyc;
      sb.push_back(x);
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(negedge clk);
      nb_label = mk(1,1,1,1,1,1,1,1,1,1);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_idle();
      repeat (2) @(negedge clk);
      check_idle_outputs("ignored_start", 9, 4, 0);

      // start held high: ignored in DONE, re-accepted in the following IDLE.
      @(negedge clk);
      nb_label = mk(7,3,3,7,0,0,0,0,0,0);
      nb_valid = 10'h00F;
      start = 1'b1;
      x.cls = 7; x.votes = 2; x.empty = 0; x.acc = cyc;
      sb.push_back(x);
      repeat (2*K + 2) @(negedge clk);
      x.acc = cyc;
      sb.push_back(x);
      @(posedge clk);
      #1 start = 1'b0;
      wait_idle();
      repeat (2) @(negedge clk);

      // Reset mid-SELECT discards the vote.
      @(negedge clk);
      nb_label = mk(4,4,4,4,4,4,4,4,4,4);
      nb_valid = 10'h3FF;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (14) @(negedge clk);
      chk("mid_select_busy", int'(busy), 1);
      rst = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      check_idle_outputs("mid_reset", 0, 0, 0);
      repeat (30) @(negedge clk);

      // Reset wins over a simultaneous start.
      rst = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1 rst = 1'b1;
      start = 1'b0;
      chk("rst_over_start_busy", int'(busy), 0);
      repeat (5) @(negedge clk);
      chk("rst_over_start_busy2", int'(busy), 0);

      vote(mk(5,2,2,5,7,7,7,5,2,1), 10'h3FF, 5, 3, 0);

      repeat (5) @(negedge clk);
      chk("sb_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
